axi_burst_ram_responder: RTL and testbench
==========================================

Name: axi_burst_ram_responder

Overview:
AXI4 memory-mapped responder (slave) backed by on-chip block RAM. It answers the INCR write and read bursts issued by the deep-FIFO AXI initiator. It stands in for DDR in simulation and in small-buffer builds. Write and read channels are independent, so one write burst and one read burst can be in flight at once.

Parameters:
base_addr, 0, byte address mapped to RAM word 0
addr_width, 32, AXI address width
log2_word_width, 5, log2 of data width in bits (32-bit words)
log2_depth_words, 12, log2 of RAM depth in words (4096 words)

Ports:
clk  in  1  single clock for all logic
reset  in  1  asynchronous reset, active high
axi_awaddr  in  addr_width  write burst start byte address
axi_awlen  in  8  beats minus 1
axi_awburst  in  2  00=FIXED, 01=INCR, 10 treated as INCR
axi_awvalid/axi_awready  in/out  1  AW handshake
axi_wdata  in  2^log2_word_width  write data
axi_wstrb  in  2^(log2_word_width-3)  byte enables
axi_wlast/axi_wvalid  in  1  last beat, W valid
axi_wready  out  1  W ready
axi_bresp/axi_bvalid  out  2/1  write response (always 00 OKAY), B valid
axi_bready  in  1  B ready
axi_araddr/axi_arlen/axi_arburst/axi_arvalid  in  addr_width/8/2/1  AR channel
axi_arready  out  1  AR ready
axi_rdata  out  2^log2_word_width  read data
axi_rresp  out  2  always 00
axi_rlast/axi_rvalid  out  1  last beat, R valid
axi_rready  in  1  R ready
protocol_error  out  1  sticky flag: wlast did not coincide with the final counted beat

Behaviour:
- Reset (async assert, sync use): axi_awready=0, axi_wready=0, axi_bvalid=0, axi_arready=0, axi_rvalid=0, axi_rlast=0, protocol_error=0; both FSMs go to IDLE.
- RAM contents are not cleared by reset.
- Reset during a burst abandons the burst. Beats already written remain in RAM.
- Word index = ((addr - base_addr) >> (log2_word_width-3)) mod 2^log2_depth_words.
- INCR advances the index by 1 per beat and wraps modulo depth. FIXED holds the index.
- awsize/arsize are not ports. Transfers are always full-word.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&&awready: latch index, beat count = awlen, burst type; go to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready writes wdata under wstrb and advances the index.
  - W_DATA, on the beat where count==0: go to W_RESP. If wlast is not set on that beat, or is set on an earlier beat, set protocol_error. The early wlast is otherwise ignored.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
  - awready is 0 outside W_IDLE, so a new AW is never accepted before B completes.
  - Minimum burst cost: 1 AW cycle + N beat cycles + 1 B cycle.
- Read FSM:
  - R_IDLE: arready=1. On arvalid&&arready: latch index, count = arlen; go to R_DATA.
  - R_DATA: RAM read enable = beats_remaining_to_fetch && (!rvalid || rready).
  - The output register is loaded under the same enable, so rdata and rlast are stable while a stall lasts.
  - Each fetch advances the index and decrements the fetch count.
  - rlast marks the beat fetched with count==0.
  - After the rlast beat handshakes: go to R_IDLE (arready=1 the next cycle).
  - Latency: AR handshake at cycle T gives first rvalid at T+2.
  - With rready held high: 1 beat/cycle with no bubbles.
- RAM: simple dual-port, one write and one read port.
- Same-cycle write and read of the same word: the read returns the old data (read-first).
- Write and read channels never block each other.
- Address arithmetic: the index counter is log2_depth_words bits and overflows naturally. addr_width bits above the index are ignored.

Test Plan:
- Write INCR, awaddr=base, awlen=15, data 0..15, wstrb all ones -> 16 wready beats, protocol_error=0. Then bvalid=1, bresp=0. A read of the same burst returns 0..15 with rlast on beat 15.
- Read with rready toggled 1,0,1,0 -> rdata/rlast held steady during the 0 cycles. No beat is lost or duplicated. First rvalid arrives 2 cycles after the AR handshake.
- Wrap-around: burst at word index 4090 with awlen=15 (depth 4096) -> data lands at 4090..4095 and then 0..9. A read from 4090 returns the same sequence.
- wstrb=0101 over a word holding 0xFFFFFFFF, wdata=0 -> readback is 0xFF00FF00. A FIXED burst of 4 beats writes only the last data to a single word.
- wlast asserted on beat 2 of awlen=3 -> protocol_error=1 and stays 1. The burst still consumes 4 beats, then bvalid asserts.
- Concurrency and reset: overlapping write and read bursts both complete at full rate. Asserting reset mid-read -> rvalid=0 and arready=0 immediately; after release, arready=1 and a new burst returns correct data.

Source files
------------

// File: rtl/axi_burst_ram_responder.sv
// AXI4 burst responder backed by a simple dual-port block RAM.
// Independent write (AW/W/B) and read (AR/R) engines share only the RAM array,
// so one write burst and one read burst can be in flight together.
`timescale 1ns/1ps

module axi_burst_ram_responder #(
  parameter int                    addr_width       = 32,
  parameter logic [addr_width-1:0] base_addr        = '0,
  parameter int                    log2_word_width  = 5,
  parameter int                    log2_depth_words = 12
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [addr_width-1:0]                 axi_awaddr,
  input  logic [7:0]                            axi_awlen,
  input  logic [1:0]                            axi_awburst,
  input  logic                                  axi_awvalid,
  output logic                                  axi_awready,
  input  logic [(1<<log2_word_width)-1:0]       axi_wdata,
  input  logic [(1<<(log2_word_width-3))-1:0]   axi_wstrb,
  input  logic                                  axi_wlast,
  input  logic                                  axi_wvalid,
  output logic                                  axi_wready,
  output logic [1:0]                            axi_bresp,
  output logic                                  axi_bvalid,
  input  logic                                  axi_bready,
  input  logic [addr_width-1:0]                 axi_araddr,
  input  logic [7:0]                            axi_arlen,
  input  logic [1:0]                            axi_arburst,
  input  logic                                  axi_arvalid,
  output logic                                  axi_arready,
  output logic [(1<<log2_word_width)-1:0]       axi_rdata,
  output logic [1:0]                            axi_rresp,
  output logic                                  axi_rlast,
  output logic                                  axi_rvalid,
  input  logic                                  axi_rready,
  output logic                                  protocol_error
);

  localparam int data_width = 1 << log2_word_width;
  localparam int strb_width = data_width / 8;
  localparam int byte_shift = log2_word_width - 3;
  localparam int depth      = 1 << log2_depth_words;

  typedef logic [log2_depth_words-1:0] index_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [data_width-1:0] mem [depth];

  // Word index is the offset from base_addr in words; bits above the index are dropped
  logic [addr_width-1:0] aw_offset;
  logic [addr_width-1:0] ar_offset;
  index_t                aw_index;
  index_t                ar_index;
  logic                  unused_offset_bits;

  assign aw_offset          = axi_awaddr - base_addr;
  assign ar_offset          = axi_araddr - base_addr;
  assign aw_index           = aw_offset[byte_shift +: log2_depth_words];
  assign ar_index           = ar_offset[byte_shift +: log2_depth_words];
  assign unused_offset_bits = ^{aw_offset, ar_offset};

  assign axi_bresp = 2'b00;
  assign axi_rresp = 2'b00;

  w_state_t   w_state;
  index_t     w_index;
  logic [7:0] w_count;
  logic       w_fixed;
  logic       w_beat;

  assign w_beat = axi_wvalid && axi_wready;

  // Write engine: accept AW, take awlen+1 beats, then hold B until it is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state        <= W_IDLE;
      axi_awready    <= 1'b0;
      axi_wready     <= 1'b0;
      axi_bvalid     <= 1'b0;
      protocol_error <= 1'b0;
      w_index        <= '0;
      w_count        <= 8'd0;
      w_fixed        <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!axi_awready) begin
            axi_awready <= 1'b1;
          end else if (axi_awvalid) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            w_index     <= aw_index;
            w_count     <= axi_awlen;
            w_fixed     <= (axi_awburst == 2'b00);
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (!w_fixed) w_index <= w_index + 1'b1;
            if (w_count == 8'd0) begin
              if (!axi_wlast) protocol_error <= 1'b1;
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              w_state    <= W_RESP;
            end else begin
              if (axi_wlast) protocol_error <= 1'b1;
              w_count <= w_count - 8'd1;
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM write port with per-byte enables
  always_ff @(posedge clk) begin
    if (w_beat) begin
      for (int b = 0; b < strb_width; b++) begin
        if (axi_wstrb[b]) mem[w_index][b*8 +: 8] <= axi_wdata[b*8 +: 8];
      end
    end
  end

  r_state_t   r_state;
  index_t     r_index;
  logic [7:0] r_count;
  logic       r_pending;
  logic       r_fixed;
  logic       r_fetch;

  assign r_fetch = (r_state == R_DATA) && r_pending && (!axi_rvalid || axi_rready);

  // Read engine: fetch a beat whenever the output slot is empty or being drained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      r_index     <= '0;
      r_count     <= 8'd0;
      r_pending   <= 1'b0;
      r_fixed     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (!axi_arready) begin
            axi_arready <= 1'b1;
          end else if (axi_arvalid) begin
            axi_arready <= 1'b0;
            r_index     <= ar_index;
            r_count     <= axi_arlen;
            r_fixed     <= (axi_arburst == 2'b00);
            r_pending   <= 1'b1;
            r_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fetch) begin
            axi_rvalid <= 1'b1;
            axi_rlast  <= (r_count == 8'd0);
            if (!r_fixed) r_index <= r_index + 1'b1;
            if (r_count == 8'd0) r_pending <= 1'b0;
            else                 r_count   <= r_count - 8'd1;
          end else if (axi_rvalid && axi_rready) begin
            axi_rvalid <= 1'b0;
            axi_rlast  <= 1'b0;
            if (axi_rlast) begin
              axi_arready <= 1'b1;
              r_state     <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // RAM read port doubles as the R data register, so it holds during stalls
  always_ff @(posedge clk) begin
    if (r_fetch) axi_rdata <= mem[r_index];
  end

endmodule

// File: tb/tb_axi_burst_ram_responder.sv
// Directed bench for axi_burst_ram_responder: bursts, stalls, wrap, strobes,
// FIXED bursts, wlast errors, concurrent channels and reset mid-burst.
`timescale 1ns/1ps

module tb_axi_burst_ram_responder;

  logic        clk;
  logic        reset;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        protocol_error;

  int checks;
  int failures;

  logic [31:0] model [4096];
  logic [31:0] lastData [256];
  logic        lastLast [256];

  axi_burst_ram_responder dut (
    .clk            (clk),
    .reset          (reset),
    .axi_awaddr     (axi_awaddr),
    .axi_awlen      (axi_awlen),
    .axi_awburst    (axi_awburst),
    .axi_awvalid    (axi_awvalid),
    .axi_awready    (axi_awready),
    .axi_wdata      (axi_wdata),
    .axi_wstrb      (axi_wstrb),
    .axi_wlast      (axi_wlast),
    .axi_wvalid     (axi_wvalid),
    .axi_wready     (axi_wready),
    .axi_bresp      (axi_bresp),
    .axi_bvalid     (axi_bvalid),
    .axi_bready     (axi_bready),
    .axi_araddr     (axi_araddr),
    .axi_arlen      (axi_arlen),
    .axi_arburst    (axi_arburst),
    .axi_arvalid    (axi_arvalid),
    .axi_arready    (axi_arready),
    .axi_rdata      (axi_rdata),
    .axi_rresp      (axi_rresp),
    .axi_rlast      (axi_rlast),
    .axi_rvalid     (axi_rvalid),
    .axi_rready     (axi_rready),
    .protocol_error (protocol_error)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a handshake loop misbehaves beyond its own bound
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    axi_awaddr  = '0;
    axi_awlen   = '0;
    axi_awburst = 2'b01;
    axi_awvalid = 1'b0;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wlast   = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_araddr  = '0;
    axi_arlen   = '0;
    axi_arburst = 2'b01;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
  endtask

  // Write burst with data dbase+i; earlyLast>=0 puts wlast on that beat only
  task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] strb, input logic [31:0] dbase, input int earlyLast);
    int cyc;
    int idx;
    @(negedge clk);
    axi_awaddr  = addr;
    axi_awlen   = len;
    axi_awburst = burst;
    axi_awvalid = 1'b1;
    cyc = 0;
    while (axi_awready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("aw_accept", (cyc < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    axi_awvalid = 1'b0;
    idx = (addr >> 2) % 4096;
    cyc = 0;
    for (int i = 0; i <= int'(len); i++) begin
      axi_wdata  = dbase + i;
      axi_wstrb  = strb;
      axi_wlast  = (earlyLast >= 0) ? (i == earlyLast) : (i == int'(len));
      axi_wvalid = 1'b1;
      while (axi_wready !== 1'b1 && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      @(negedge clk);
      cyc++;
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[idx][b*8 +: 8] = axi_wdata[b*8 +: 8];
      end
      if (burst != 2'b00) idx = (idx + 1) % 4096;
    end
    axi_wvalid = 1'b0;
    axi_wlast  = 1'b0;
    checkOutput("w_beat_cycles", cyc, int'(len) + 1);
    cyc = 0;
    while (axi_bvalid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("bvalid", axi_bvalid, 1);
    checkOutput("bresp", axi_bresp, 0);
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    checkOutput("bvalid_clear", axi_bvalid, 0);
    checkOutput("awready_after_b", axi_awready, 1);
  endtask

  // Read burst; toggle drives rready 1,0,1,0... and checks the held beat
  task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input bit toggle);
    int cyc, got, lat, firstCyc, lastCyc, idx;
    bit seen, stalled, phase;
    logic [31:0] hd;
    logic        hl;
    for (int i = 0; i < 256; i++) begin
      lastData[i] = 'x;
      lastLast[i] = 1'bx;
    end
    @(negedge clk);
    axi_araddr  = addr;
    axi_arlen   = len;
    axi_arburst = burst;
    axi_arvalid = 1'b1;
    cyc = 0;
    while (axi_arready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ar_accept", (cyc < 50) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    axi_arvalid = 1'b0;
    lat = 1; got = 0; seen = 0; stalled = 0; phase = 1; cyc = 0;
    firstCyc = 0; lastCyc = 0; hd = '0; hl = 1'b0;
    while (got <= int'(len) && cyc < 400) begin
      axi_rready = toggle ? phase : 1'b1;
      if (axi_rvalid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          firstCyc = cyc;
          checkOutput("first_rvalid_latency", lat, 2);
        end
        if (stalled) begin
          checkOutput("r_hold_data", axi_rdata, hd);
          checkOutput("r_hold_last", axi_rlast, hl);
        end
        if (axi_rready) begin
          lastData[got] = axi_rdata;
          lastLast[got] = axi_rlast;
          got++;
          lastCyc = cyc;
          stalled = 0;
        end else begin
          stalled = 1;
          hd = axi_rdata;
          hl = axi_rlast;
        end
      end
      phase = !phase;
      @(negedge clk);
      cyc++;
      if (!seen) lat++;
    end
    axi_rready = 1'b0;
    checkOutput("r_beats", got, int'(len) + 1);
    checkOutput("r_no_extra_rvalid", axi_rvalid, 0);
    checkOutput("arready_after_rlast", axi_arready, 1);
    if (!toggle) checkOutput("r_beat_span", lastCyc - firstCyc + 1, int'(len) + 1);
    idx = (addr >> 2) % 4096;
    for (int i = 0; i <= int'(len); i++) begin
      checkOutput($sformatf("r_data[%0d]", i), lastData[i], model[idx]);
      checkOutput($sformatf("r_last[%0d]", i), lastLast[i], (i == int'(len)) ? 32'd1 : 32'd0);
      if (burst != 2'b00) idx = (idx + 1) % 4096;
    end
  endtask

  // Directed sequence
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus();

    repeat (2) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("rst_awready", axi_awready, 0);
    checkOutput("rst_wready", axi_wready, 0);
    checkOutput("rst_bvalid", axi_bvalid, 0);
    checkOutput("rst_arready", axi_arready, 0);
    checkOutput("rst_rvalid", axi_rvalid, 0);
    checkOutput("rst_rlast", axi_rlast, 0);
    checkOutput("rst_protocol_error", protocol_error, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_awready", axi_awready, 1);
    checkOutput("idle_arready", axi_arready, 1);

    $display("[TB] INCR write 0..15 and readback");
    writeBurst(32'h0, 8'd15, 2'b01, 4'hF, 32'h0, -1);
    checkOutput("perr_clean_write", protocol_error, 0);
    readBurst(32'h0, 8'd15, 2'b01, 1'b0);
    checkOutput("hand_word3", lastData[3], 32'd3);
    checkOutput("hand_word15", lastData[15], 32'd15);

    $display("[TB] read with rready toggling");
    readBurst(32'h0, 8'd15, 2'b01, 1'b1);

    $display("[TB] wrap-around at index 4090");
    writeBurst(32'd4090 * 4, 8'd15, 2'b01, 4'hF, 32'h100, -1);
    readBurst(32'd4090 * 4, 8'd15, 2'b01, 1'b0);
    checkOutput("wrap_4095", lastData[5], 32'h105);
    readBurst(32'h0, 8'd10, 2'b01, 1'b0);
    checkOutput("wrap_word0", lastData[0], 32'h106);
    checkOutput("wrap_word9", lastData[9], 32'h10F);
    checkOutput("wrap_word10_untouched", lastData[10], 32'd10);

    $display("[TB] byte strobes");
    writeBurst(32'd50 * 4, 8'd0, 2'b01, 4'hF, 32'hFFFFFFFF, -1);
    writeBurst(32'd50 * 4, 8'd0, 2'b01, 4'b0101, 32'h0, -1);
    readBurst(32'd50 * 4, 8'd0, 2'b01, 1'b0);
    checkOutput("strobe_merge", lastData[0], 32'hFF00FF00);

    $display("[TB] FIXED burst");
    writeBurst(32'd101 * 4, 8'd0, 2'b01, 4'hF, 32'h12345678, -1);
    writeBurst(32'd100 * 4, 8'd3, 2'b00, 4'hF, 32'hA0, -1);
    readBurst(32'd100 * 4, 8'd1, 2'b01, 1'b0);
    checkOutput("fixed_last_data", lastData[0], 32'hA3);
    checkOutput("fixed_neighbor", lastData[1], 32'h12345678);
    checkOutput("perr_before_error", protocol_error, 0);

    $display("[TB] early wlast");
    writeBurst(32'd300 * 4, 8'd3, 2'b01, 4'hF, 32'h300, 2);
    checkOutput("perr_set", protocol_error, 1);
    writeBurst(32'd310 * 4, 8'd1, 2'b01, 4'hF, 32'h310, -1);
    checkOutput("perr_sticky", protocol_error, 1);
    readBurst(32'd300 * 4, 8'd3, 2'b01, 1'b0);

    $display("[TB] concurrent write and read");
    fork
      writeBurst(32'd200 * 4, 8'd7, 2'b01, 4'hF, 32'h200, -1);
      readBurst(32'h0, 8'd15, 2'b01, 1'b0);
    join
    readBurst(32'd200 * 4, 8'd7, 2'b01, 1'b0);

    $display("[TB] reset during read");
    @(negedge clk);
    axi_araddr  = 32'h0;
    axi_arlen   = 8'd15;
    axi_arburst = 2'b01;
    axi_arvalid = 1'b1;
    axi_rready  = 1'b1;
    @(negedge clk);
    axi_arvalid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midread_rvalid_before", axi_rvalid, 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_rvalid", axi_rvalid, 0);
    checkOutput("midreset_arready", axi_arready, 0);
    checkOutput("midreset_rlast", axi_rlast, 0);
    checkOutput("midreset_perr", protocol_error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("postreset_arready", axi_arready, 1);
    readBurst(32'd4090 * 4, 8'd15, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
